// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched {pc, instr} entries; flush beats push and pop.
// While empty, dout keeps showing the most recently presented head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int           DEPTH       = 2,
    parameter fetch_entry_t RESET_ENTRY = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               din,
    output fetch_entry_t               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    fetch_entry_t    hold_reg;
    fetch_entry_t    head;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign dout    = empty ? hold_reg : head;
    // Writing when full is legal only alongside a pop of the slot being overwritten.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            hold_reg   <= RESET_ENTRY;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            if (!empty) begin
                hold_reg <= head;
            end
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                hold_reg   <= head;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, combinational imem address, queue toward decode.
// Optional FETCH_MISALIGN_EN adds a sticky misaligned-redirect trap (fetch_misalign).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_reg;
    logic [31:0]   pc_reg;
    logic [31:0]   redirect_target;
    logic          misalign_hit;
    logic          locked;
    logic          push;
    logic          pop;
    logic          flush;
    logic [CW-1:0] queue_count;
    logic          queue_empty;
    logic          unused_full;
    fetch_entry_t  head;

`ifdef FETCH_MISALIGN_EN
    logic misalign_reg;

    assign redirect_target = redirect_pc;
    assign misalign_hit    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign locked          = misalign_reg;
    assign fetch_misalign  = misalign_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else if (misalign_hit) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign misalign_hit    = 1'b0;
    assign locked          = 1'b0;
`endif

    assign imem_addr = pc_reg;
    assign id_valid  = !queue_empty;
    // A redirect cancels both this cycle's fetch and the consumption of the head.
    assign pop   = id_valid && id_ready && !redirect_valid;
    assign push  = (state_reg == RUN) && !halt_req && !redirect_valid &&
                   ((queue_count < CW'(DEPTH)) || pop);
    assign flush = redirect_valid;

    fetch_queue #(
        .DEPTH       (DEPTH),
        .RESET_ENTRY (fetch_entry_t'{pc: RESET_PC, instr: INSTR_NOP})
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (fetch_entry_t'{pc: pc_reg, instr: imem_rd}),
        .dout  (head),
        .count (queue_count),
        .full  (unused_full),
        .empty (queue_empty)
    );

    assign id_pc       = head.pc;
    assign id_instr    = head.instr;
    assign id_pc_plus4 = next_pc(head.pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= RUN;
                RUN:     if (halt_req)  state_reg <= HALTED;
                HALTED:  if (!halt_req) state_reg <= RUN;
                default: state_reg <= BOOT;
            endcase
            // A misaligned trap pins the unit in HALTED until reset.
            if (locked || misalign_hit) begin
                state_reg <= HALTED;
            end

            if (misalign_hit) begin
                pc_reg <= pc_reg;
            end else if (redirect_valid) begin
                pc_reg <= redirect_target;
            end else if (push) begin
                pc_reg <= next_pc(pc_reg);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns word index (addr >> 2).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_MISALIGN_EN
    logic        fetch_misalign;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rd = imem_addr >> 2;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its BOOT cycle with reset released.
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        id_ready       = 1'b0;

        // Reset state, with a redirect presented during reset that must be dropped.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check("rst_valid", {31'b0, id_valid}, 32'h0);
        check("rst_instr", id_instr, 32'h0000_0013);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc_plus4, 32'h4);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming with id_ready high.
        reset    = 1'b0;
        id_ready = 1'b1;
        step();
        check("boot_addr", imem_addr, 32'h0);
        check("boot_valid", {31'b0, id_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("stream_valid%0d", k), {31'b0, id_valid}, 32'h1);
            check($sformatf("stream_pc%0d", k), id_pc, 32'(4 * k));
            check($sformatf("stream_instr%0d", k), id_instr, 32'(k));
            check($sformatf("stream_addr%0d", k), imem_addr, 32'(4 * k + 4));
        end

        // Back-pressure: queue fills with PC 0 and 4, pc stalls at 8.
        id_ready = 1'b0;
        do_reset();
        repeat (5) step();
        check("stall_addr", imem_addr, 32'h8);
        check("stall_pc", id_pc, 32'h0);
        check("stall_valid", {31'b0, id_valid}, 32'h1);
        id_ready = 1'b1;
        step();
        check("drain_pc1", id_pc, 32'h4);
        check("drain_addr1", imem_addr, 32'hC);
        step();
        check("drain_pc2", id_pc, 32'h8);
        check("drain_instr2", id_instr, 32'h2);
        check("drain_addr2", imem_addr, 32'h10);

        // Redirect while full and being consumed.
        id_ready = 1'b0;
        do_reset();
        repeat (3) step();
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        check("redir_valid", {31'b0, id_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h100);
        step();
        check("redir_head_valid", {31'b0, id_valid}, 32'h1);
        check("redir_head_pc", id_pc, 32'h100);
        check("redir_head_instr", id_instr, 32'h40);

        // Halt for three cycles, then resume at the frozen pc.
        id_ready = 1'b1;
        do_reset();
        step();
        step();
        halt_req = 1'b1;
        step();
        check("halt_valid", {31'b0, id_valid}, 32'h0);
        check("halt_addr", imem_addr, 32'h4);
        step();
        step();
        check("halt_addr_hold", imem_addr, 32'h4);
        halt_req = 1'b0;
        step();
        check("resume_valid", {31'b0, id_valid}, 32'h0);
        check("resume_addr", imem_addr, 32'h4);
        step();
        check("resume_pc", id_pc, 32'h4);
        check("resume_instr", id_instr, 32'h1);

        // PC wrap at the top of the address space.
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        step();
        check("wrap_pc0", id_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", id_instr, 32'h3FFF_FFFE);
        step();
        check("wrap_pc1", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4_1", id_pc_plus4, 32'h0);
        check("wrap_addr1", imem_addr, 32'h0);
        step();
        check("wrap_pc2", id_pc, 32'h0);
        check("wrap_pc4_2", id_pc_plus4, 32'h4);

`ifdef FETCH_MISALIGN_EN
        // Misaligned redirect traps and holds the unit halted.
        id_ready = 1'b0;
        do_reset();
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        check("mis_flag", {31'b0, fetch_misalign}, 32'h1);
        check("mis_valid", {31'b0, id_valid}, 32'h0);
        check("mis_addr", imem_addr, 32'h4);
        id_ready = 1'b1;
        repeat (3) step();
        check("mis_flag_hold", {31'b0, fetch_misalign}, 32'h1);
        check("mis_valid_hold", {31'b0, id_valid}, 32'h0);
        check("mis_addr_hold", imem_addr, 32'h4);
        do_reset();
        check("mis_flag_clear", {31'b0, fetch_misalign}, 32'h0);
`else
        // Without the trap, low redirect bits are dropped.
        do_reset();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        check("align_addr", imem_addr, 32'h100);
        step();
        check("align_pc", id_pc, 32'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the combinational instruction memory and feeding decode.
- Owns the PC register and drives the memory word address.
- Captures the returned instruction word into a small in-order queue.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Supports branch/jump redirect (queue flush) and a halt request.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch-queue entries (power of two, >=2).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
imem_addr  out  32  byte address to instruction memory; always equals the PC register.
imem_rd  in  32  instruction word returned combinationally for imem_addr, same cycle.
redirect_valid  in  1  single-cycle request to change the fetch PC.
redirect_pc  in  32  target PC for redirect.
halt_req  in  1  level; stop fetching while high.
id_valid  out  1  queue head is valid.
id_ready  in  1  decode accepts the head this cycle.
id_instr  out  32  head instruction word.
id_pc  out  32  head PC.
id_pc_plus4  out  32  head PC + 4, modulo 2^32.

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: pc=RESET_PC, queue count=0, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, state=BOOT.
- Reset asserted mid-operation discards all queue contents and any redirect presented that cycle.
- FSM states and transitions:
  - BOOT -> RUN after one cycle; no fetch in BOOT.
  - RUN -> HALTED when halt_req=1 (sampled at the clock edge).
  - HALTED -> RUN when halt_req=0.
- Handshake signals:
  - push = (state==RUN) && !halt_req && (count<DEPTH || pop).
  - pop = id_valid && id_ready.
- On push: enqueue {pc, imem_rd}; pc <= pc+4. Wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Push and pop may occur in the same cycle, including when full; count is unchanged.
- Pop when empty is impossible because id_valid=0.
- Latency: an instruction fetched in cycle N is visible at the decode outputs in cycle N+1 (registered queue). Back-to-back throughput is 1 instruction/cycle with id_ready=1.
- Redirect has priority over push and pop:
  - queue flushed (count<=0);
  - pc <= redirect_pc;
  - no push that cycle, and the head is not considered popped;
  - the next cycle, id_valid=0 and imem_addr=redirect_pc.
- Redirect in HALTED or BOOT updates pc and flushes; the state is unchanged.
- When the queue is empty, outputs hold the last head values; consumers qualify them with id_valid.
- imem_addr is combinational from the pc register only (no input-to-output combinational path).

Optional Feature:
Macro FETCH_MISALIGN_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit, reset 0, sticky until reset).
  - A redirect with redirect_pc[1:0]!=2'b00 sets fetch_misalign, flushes the queue, leaves pc unchanged and forces state to HALTED.
  - The unit then stays HALTED regardless of halt_req until reset.
- Undefined: no port; redirect_pc[1:0] are ignored and forced to 2'b00.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HALTED};
  - fetch_entry_t packed struct {pc[31:0], instr[31:0]};
  - localparam INSTR_NOP=32'h0000_0013;
  - localparam PC_STEP=4.
- One sub-module, fetch_queue: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - flush has priority over push and pop.

Test Plan:
- Reset then id_ready=1 constantly, memory word k = k -> imem_addr 0,4,8,... from the cycle after BOOT; id_valid rises one cycle after the first fetch; id_instr 0,1,2 with id_pc 0,4,8 on consecutive cycles.
- id_ready=0 for 5 cycles after start -> exactly DEPTH=2 pushes, pc stalls at 8, imem_addr=8; release -> entries at PC 0 and 4 drain in order, fetch resumes at 8 with no gap.
- Full queue with id_ready=1 and redirect_valid=1, redirect_pc=0x100 in the same cycle -> next cycle id_valid=0, imem_addr=0x100; following cycle id_pc=0x100; the in-flight head is not consumed.
- halt_req=1 for 3 cycles with id_ready=1 -> queue drains, no new pushes, pc frozen; halt_req=0 -> RUN resumes at the frozen pc.
- Redirect to 0xFFFF_FFF8 -> fetched PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; id_pc_plus4 for 0xFFFF_FFFC is 0x0000_0000.
- FETCH_MISALIGN_EN defined, redirect_pc=0x102 -> fetch_misalign=1 next cycle, id_valid=0, pc unchanged, stays HALTED with halt_req=0 until reset clears it.
